// File: rtl/imem_boot_loader.sv
// Byte-stream instruction image loader: frames a host byte stream into words, writes them
// to instruction memory and releases the CPU reset once the frame checksum is verified.
module imem_boot_loader #(
    parameter logic [31:0] TEXT_BASE = 32'h0000_3000,
    parameter int          MAX_WORDS = 1024,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             reload,
    output logic             imem_we,
    output logic [31:0]      imem_addr,
    output logic [31:0]      imem_wdata,
    output logic             cpu_rst,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] words_loaded
);

    typedef enum logic [2:0] {
        S_CNT_HI,
        S_CNT_LO,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [16:0] MAX_CNT = 17'(MAX_WORDS);

    state_t      state;
    state_t      state_next;
    logic [15:0] cnt;
    logic [15:0] cnt_full;
    logic [23:0] shift;
    logic [1:0]  byte_idx;
    logic [7:0]  chk;
    logic        accept;
    logic        word_done;
    logic        last_word;
    logic        rearm;

    assign accept    = in_valid && in_ready;
    assign cnt_full  = {cnt[15:8], in_data};
    assign word_done = (state == S_DATA) && in_valid && (byte_idx == 2'd3);
    // The final word retires the frame on the same edge its write is launched.
    assign last_word = word_done && ((32'(words_loaded) + 32'd1) == 32'(cnt));
    assign rearm     = reload && ((state == S_DONE) || (state == S_ERR));

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_next = state;
        in_ready   = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        cpu_rst    = 1'b1;
        case (state)
            S_CNT_HI: begin
                in_ready = 1'b1;
                if (in_valid) state_next = S_CNT_LO;
            end
            S_CNT_LO: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if ({1'b0, cnt_full} > MAX_CNT) state_next = S_ERR;
                    else if (cnt_full == 16'd0)     state_next = S_CHK;
                    else                            state_next = S_DATA;
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                if (last_word) state_next = S_CHK;
            end
            S_CHK: begin
                in_ready = 1'b1;
                if (in_valid) state_next = (in_data == chk) ? S_DONE : S_ERR;
            end
            S_DONE: begin
                done    = 1'b1;
                cpu_rst = 1'b0;
                if (reload) state_next = S_CNT_HI;
            end
            S_ERR: begin
                err = 1'b1;
                if (reload) state_next = S_CNT_HI;
            end
            default: state_next = S_CNT_HI;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (rst) state <= S_CNT_HI;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            imem_we      <= 1'b0;
            imem_addr    <= TEXT_BASE;
            imem_wdata   <= 32'd0;
            words_loaded <= '0;
            cnt          <= 16'd0;
            shift        <= 24'd0;
            byte_idx     <= 2'd0;
            chk          <= 8'd0;
        end else begin
            imem_we <= 1'b0;
            if (rearm) begin
                words_loaded <= '0;
                chk          <= 8'd0;
                byte_idx     <= 2'd0;
            end
            if (accept) begin
                case (state)
                    S_CNT_HI: begin
                        cnt[15:8] <= in_data;
                        chk       <= chk ^ in_data;
                    end
                    S_CNT_LO: begin
                        cnt[7:0] <= in_data;
                        chk      <= chk ^ in_data;
                        byte_idx <= 2'd0;
                    end
                    S_DATA: begin
                        shift    <= {shift[15:0], in_data};
                        chk      <= chk ^ in_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            imem_we      <= 1'b1;
                            imem_addr    <= TEXT_BASE + 32'({words_loaded, 2'b00});
                            imem_wdata   <= {shift, in_data};
                            words_loaded <= words_loaded + CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: table of whole frames plus hand-written
// overflow, boundary-count and mid-frame reset sequences; writes checked via a scoreboard.
module tb_imem_boot_loader;

    localparam logic [31:0] TEXT_BASE = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        reload;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        err;
    logic [15:0] words_loaded;

    int checks = 0;
    int errors = 0;

    logic [63:0] sb [$];

    typedef struct {
        int n;
        int kind;
        bit flip;
        bit gaps;
        bit exp_done;
        bit exp_err;
    } vec_t;

    vec_t vecs [6];

    imem_boot_loader #(
        .TEXT_BASE(TEXT_BASE),
        .MAX_WORDS(1024),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .reload(reload),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_rst(cpu_rst),
        .done(done),
        .err(err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input int kind, input int i);
        logic [31:0] plan [3];
        plan = '{32'h2008_0005, 32'h2009_000C, 32'h0109_5020};
        case (kind)
            0:       return plan[i];
            2:       return 32'hAC02_0050;
            default: return 32'h1357_9BDF ^ (32'(i) * 32'h0101_0111) ^ {16'(i), 16'(i * 7)};
        endcase
    endfunction

    // Write monitor: each cycle with imem_we high must match the oldest expected write.
    always @(negedge clk) begin
        logic [63:0] e;
        if (imem_we === 1'b1) begin
            check("write_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("write_addr", imem_addr, e[63:32]);
                check("write_data", imem_wdata, e[31:0]);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the byte is accepted.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int waited = 0;
        if (gaps) repeat ($urandom_range(0, 1)) @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("ready_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic send_words(input int n_field, input int kind, input int nsend,
                              input bit gaps, output logic [7:0] x);
        logic [15:0] c;
        logic [31:0] w;
        c = 16'(n_field);
        x = c[15:8] ^ c[7:0];
        send_byte(c[15:8], gaps);
        send_byte(c[7:0], gaps);
        for (int i = 0; i < nsend; i++) begin
            w = word_of(kind, i);
            sb.push_back({TEXT_BASE + 32'(i) * 32'd4, w});
            for (int b = 3; b >= 0; b--) begin
                send_byte(w[b*8 +: 8], gaps);
                x = x ^ w[b*8 +: 8];
            end
        end
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        check("reload_err", 32'(err), 32'd0);
        check("reload_done", 32'(done), 32'd0);
        check("reload_ready", 32'(in_ready), 32'd1);
        check("reload_cpu_rst", 32'(cpu_rst), 32'd1);
        check("reload_words", 32'(words_loaded), 32'd0);
    endtask

    task automatic check_reset_values();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_imem_addr", imem_addr, TEXT_BASE);
        check("rst_imem_wdata", imem_wdata, 32'd0);
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] x;

        vecs[0] = '{n: 3,  kind: 0, flip: 1'b0, gaps: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
        vecs[1] = '{n: 3,  kind: 0, flip: 1'b1, gaps: 1'b0, exp_done: 1'b0, exp_err: 1'b1};
        vecs[2] = '{n: 1,  kind: 2, flip: 1'b0, gaps: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
        vecs[3] = '{n: 0,  kind: 1, flip: 1'b0, gaps: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
        vecs[4] = '{n: 41, kind: 1, flip: 1'b0, gaps: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
        vecs[5] = '{n: 41, kind: 1, flip: 1'b0, gaps: 1'b1, exp_done: 1'b1, exp_err: 1'b0};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        reload   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_values();

        for (int v = 0; v < 6; v++) begin
            if (done || err) pulse_reload();
            send_words(vecs[v].n, vecs[v].kind, vecs[v].n, vecs[v].gaps, x);
            if (vecs[v].flip) x = x ^ 8'h01;
            check("pre_chk_done", 32'(done), 32'd0);
            check("pre_chk_cpu_rst", 32'(cpu_rst), 32'd1);
            send_byte(x, vecs[v].gaps);
            check("frame_done", 32'(done), 32'(vecs[v].exp_done));
            check("frame_err", 32'(err), 32'(vecs[v].exp_err));
            check("frame_cpu_rst", 32'(cpu_rst), 32'(!vecs[v].exp_done));
            check("frame_in_ready", 32'(in_ready), 32'd0);
            check("frame_words", 32'(words_loaded), 32'(vecs[v].n));
            check("frame_writes_drained", 32'(sb.size()), 32'd0);
        end

        // Count above MAX_WORDS: rejected right after CNT_LO, later bytes ignored.
        pulse_reload();
        send_byte(8'h04, 1'b0);
        send_byte(8'h01, 1'b0);
        check("ovf_err", 32'(err), 32'd1);
        check("ovf_in_ready", 32'(in_ready), 32'd0);
        check("ovf_cpu_rst", 32'(cpu_rst), 32'd1);
        in_data  = 8'h55;
        in_valid = 1'b1;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        check("ovf_hold_err", 32'(err), 32'd1);
        check("ovf_hold_done", 32'(done), 32'd0);
        check("ovf_hold_words", 32'(words_loaded), 32'd0);

        // Count exactly MAX_WORDS is accepted; abandon it with rst.
        pulse_reload();
        send_byte(8'h04, 1'b0);
        send_byte(8'h00, 1'b0);
        check("max_cnt_err", 32'(err), 32'd0);
        check("max_cnt_ready", 32'(in_ready), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values();

        // Reset after two words of a five-word frame, then a fresh two-word frame.
        send_words(5, 1, 2, 1'b0, x);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values();
        check("midrst_writes_drained", 32'(sb.size()), 32'd0);
        send_words(2, 1, 2, 1'b0, x);
        send_byte(x, 1'b0);
        check("fresh_done", 32'(done), 32'd1);
        check("fresh_cpu_rst", 32'(cpu_rst), 32'd0);
        check("fresh_words", 32'(words_loaded), 32'd2);
        check("fresh_writes_drained", 32'(sb.size()), 32'd0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Byte-stream program loader. Writes a framed instruction image into instruction memory and holds the CPU in reset until the image is complete and its checksum passes.
- Sits between a host byte source (UART/debug link) and the CPU's instruction memory write port.
- It is the writer side of the instruction memory the CPU fetches from, and replaces file-based preloading for hardware runs.

Parameters:
- TEXT_BASE, 32'h0000_3000, byte address of the first loaded word. Must equal the CPU's reset PC.
- MAX_WORDS, 1024, instruction memory depth in words. A larger count field is rejected.
- CNT_W, 16, width of the word-count field and of the words_loaded output.

Ports:
- clk, input, 1, system clock. All logic is on the rising edge.
- rst, input, 1, synchronous active-high reset.
- in_data, input, 8, incoming byte.
- in_valid, input, 1, in_data is valid.
- in_ready, output, 1, loader accepts a byte. A transfer occurs when in_valid && in_ready at the clock edge.
- reload, input, 1, single-cycle pulse; re-arms the loader from DONE or ERROR.
- imem_we, output, 1, instruction memory write strobe.
- imem_addr, output, 32, byte address of the write: TEXT_BASE + 4*index.
- imem_wdata, output, 32, instruction word.
- cpu_rst, output, 1, reset to the CPU; high while not loaded.
- done, output, 1, image loaded and checksum good.
- err, output, 1, frame rejected.
- words_loaded, output, CNT_W, words written so far in the current frame.

Behaviour:
- Frame format, in byte order:
  - CNT_HI, CNT_LO: word count N, big-endian.
  - N words, 4 bytes each, MSB first.
  - CHK byte: XOR of every preceding byte of the frame, including the count bytes.
- Reset values: in_ready=1, imem_we=0, imem_addr=TEXT_BASE, imem_wdata=0, cpu_rst=1, done=0, err=0, words_loaded=0, state=S_CNT_HI. The byte counter and the running checksum are 0.
- States: S_CNT_HI, S_CNT_LO, S_DATA, S_CHK, S_DONE, S_ERR.
  - S_CNT_HI: on accept, latch cnt[15:8], go to S_CNT_LO.
  - S_CNT_LO: on accept, latch cnt[7:0].
    - N > MAX_WORDS: go to S_ERR.
    - N == 0: go to S_CHK.
    - Otherwise: go to S_DATA.
  - S_DATA: each accepted byte is shifted into a 32-bit assembly register, MSB first.
    - On the 4th byte of a word, imem_we=1 for exactly the next cycle, with imem_addr = TEXT_BASE + 4*words_loaded (pre-increment value) and imem_wdata = the assembled word.
    - words_loaded increments in the same cycle imem_we is high.
    - After the write of word N, go to S_CHK.
    - Back-to-back bytes at full rate are accepted; in_ready stays 1 throughout S_DATA.
  - S_CHK: on accept, compare the byte with the running XOR.
    - Equal: go to S_DONE.
    - Not equal: go to S_ERR.
  - S_DONE: done=1, cpu_rst=0 (from the cycle after the CHK byte is accepted), in_ready=0.
  - S_ERR: err=1, cpu_rst=1, in_ready=0. Memory already written is not rolled back.
- Running XOR covers every accepted byte except the CHK byte itself.
- in_valid while in_ready=0: ignored, no state change.
- reload in S_DONE or S_ERR, registered:
  - Next cycle: state=S_CNT_HI, cpu_rst=1, done=0, err=0, words_loaded=0, checksum=0, in_ready=1.
  - reload in any other state is ignored.
- rst mid-frame: all outputs return to reset values on the next edge. The partial frame is discarded; earlier memory writes persist.
- Simultaneous rst and reload: rst wins.
- imem_addr is held at the last written address between writes. Addresses never wrap: N ≤ MAX_WORDS guarantees this.

Test Plan:
- N=3, words 0x20080005, 0x2009000C, 0x01095020, correct XOR, bytes every cycle -> three imem_we pulses at 0x3000, 0x3004, 0x3008 with those data; words_loaded=3; done=1 and cpu_rst=0 one cycle after the CHK byte; in_ready=0 afterwards.
- Same frame with CHK bit 0 flipped -> all three writes occur, err=1, done=0, cpu_rst stays 1.
- Count 0x0000 followed by CHK=0x00 -> no imem_we, done=1. Count 0x0401 with MAX_WORDS=1024 -> err=1 immediately after CNT_LO; further in_valid bytes are not accepted.
- Random in_valid gaps (~50% duty) on a 41-word frame -> 41 writes with ascending addresses 0x3000..0x30A0, words identical to the gap-free run, done=1.
- rst asserted for 1 cycle after 2 data words of a 5-word frame, then a full fresh 2-word frame -> reset values observed, then words_loaded=2, done=1, writes at 0x3000 and 0x3004.
- After the error case, pulse reload, send a valid 1-word frame 0xAC020050 -> err clears next cycle, one write at 0x3000, done=1.
